fetch_unit: RTL

Instruction fetch stage of the astrio core, the first pipeline stage upstream of decode. It owns the program counter, the instruction ROM of `INST_SPACE` bytes mapped at `INST_START`, and a 2-entry output buffer. It delivers one `{pc, instruction}` pair per cycle to decode over a valid/ready handshake. It accepts redirects from execute and flags out-of-range and misaligned fetches.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the astrio core.
// Owns the program counter, the instruction ROM (INST_SPACE bytes mapped at
// INST_START) and a 2-entry output buffer feeding decode over valid/ready.
//
// Ports:
//   clk            - clock, rising-edge active
//   rst            - synchronous active-high reset (ROM contents unaffected)
//   load_en        - ROM write strobe for program loading
//   load_addr      - byte address of the ROM word to write
//   load_data      - ROM word to write
//   redirect_valid - taken branch/jump from execute (highest priority)
//   redirect_pc    - redirect target byte address
//   out_valid      - buffer head holds an entry
//   out_ready      - decode accepts the head this cycle
//   out_pc         - byte address of the head instruction
//   out_inst       - head instruction word (NOP on fault)
//   out_fault      - head fetch was out of range or misaligned
module fetch_unit #(
  parameter int unsigned INST_SPACE = 1024,
  parameter logic [31:0] INST_START = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  localparam int unsigned DEPTH = INST_SPACE / 4;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0]  S_RUN  = 1'b0;
  localparam logic [0:0]  S_HALT = 1'b1;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [32:0] LO     = {1'b0, INST_START};
  localparam logic [32:0] HI     = LO + 33'(INST_SPACE);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  // 33-bit bounds so INST_START+INST_SPACE cannot wrap.
  function automatic logic in_range(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} >= LO) && ({1'b0, a} < HI);
  endfunction

  logic [31:0]   rom [DEPTH];
  logic [31:0]   rom_q;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [1:0]    count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   fl_pc_q, fl_pc_d;
  logic          fl_fault_q, fl_fault_d;
  entry_t        head_q, head_d;
  entry_t        tail_q, tail_d;

  logic [31:0]   fetch_addr;
  logic          fetch_ok;
  logic [31:0]   off_f, off_l;
  logic [AW-1:0] fetch_idx, load_idx;
  logic          load_ok;
  logic          pop, issue, rom_re;
  logic [1:0]    cnt;
  entry_t        landed;
  logic          unused_bits;

  assign fetch_addr  = pc_q + 32'd4;
  assign fetch_ok    = in_range(fetch_addr);
  assign off_f       = fetch_addr - INST_START;
  assign off_l       = load_addr - INST_START;
  assign fetch_idx   = off_f[AW+1:2];
  assign load_idx    = off_l[AW+1:2];
  assign load_ok     = load_en && in_range(load_addr);
  assign unused_bits = ^{off_f[31:AW+2], off_f[1:0], off_l[31:AW+2], off_l[1:0]};

  assign pop    = (count_q != 2'd0) && out_ready;
  // A slot freed by this cycle's pop counts as free, otherwise the
  // reservation would insert a bubble every other cycle under full throughput.
  assign issue  = (state_q == S_RUN) && !redirect_valid &&
                  ((3'(count_q) - 3'(pop) + 3'(inflight_q)) < 3'd2);
  assign rom_re = issue && fetch_ok;

  always_comb begin
    landed.pc    = fl_pc_q;
    landed.inst  = fl_fault_q ? NOP : rom_q;
    landed.fault = fl_fault_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    fl_pc_d    = fl_pc_q;
    fl_fault_d = fl_fault_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt        = count_q;
    if (redirect_valid) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      pc_d       = redirect_pc - 32'd4;
      state_d    = S_RUN;
    end else begin
      cnt = count_q - {1'b0, pop};
      if (pop) head_d = tail_q;
      if (inflight_q) begin
        if (cnt == 2'd0) head_d = landed;
        else             tail_d = landed;
        cnt = cnt + 2'd1;
      end
      count_d    = cnt;
      inflight_d = issue;
      if (issue) begin
        pc_d       = fetch_addr;
        fl_pc_d    = fetch_addr;
        fl_fault_d = !fetch_ok;
        if (!fetch_ok) state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= INST_START - 32'd4;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      fl_pc_q    <= '0;
      fl_fault_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      fl_pc_q    <= fl_pc_d;
      fl_fault_q <= fl_fault_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // ROM is outside reset; nonblocking read+write gives old data on collision.
  always_ff @(posedge clk) begin
    if (load_ok) rom[load_idx] <= load_data;
    if (rom_re)  rom_q <= rom[fetch_idx];
  end

  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head_q.pc;
  assign out_inst  = head_q.inst;
  assign out_fault = head_q.fault;

endmodule
